// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered ALU control decoder (ID/EX stage) with valid/flush, JR and
// illegal flags. Define ALU_MULDIV_EN to add the stalling MULT/DIV sequencer.
module alu_control_pipe #(
   parameter int unsigned OP_WIDTH      = 4,
   parameter int unsigned MULDIV_CYCLES = 32,
   parameter int unsigned ILLEGAL_CODE  = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                flush,
   input  logic                valid_in,
   input  logic [2:0]          ALUOp,
   input  logic [5:0]          ALUFunction,
   output logic [OP_WIDTH-1:0] ALUOperation,
   output logic                valid_out,
   output logic                jr_flag,
   output logic                illegal,
   output logic                muldiv_start,
   output logic                muldiv_busy,
   output logic                muldiv_done,
   output logic                stall
);

   if (OP_WIDTH < 4 || MULDIV_CYCLES < 1) begin : g_param_check
      $error("alu_control_pipe: OP_WIDTH must be >= 4 and MULDIV_CYCLES >= 1");
   end

   logic [OP_WIDTH-1:0] w_code;
   logic                w_jr;
   logic                w_illegal;
`ifdef ALU_MULDIV_EN
   logic                w_muldiv;
`endif

   logic [OP_WIDTH-1:0] r_op;
   logic                r_valid;
   logic                r_jr;
   logic                r_illegal;

   always_comb begin
      w_code    = '0;
      w_jr      = 1'b0;
      w_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
      w_muldiv  = 1'b0;
`endif
      case (ALUOp)
         3'b000: w_code = OP_WIDTH'(4'd4);
         3'b001: w_code = OP_WIDTH'(4'd0);
         3'b010: w_code = OP_WIDTH'(4'd3);
         3'b011: w_code = OP_WIDTH'(4'd3);
         3'b100: w_code = OP_WIDTH'(4'd5);
         3'b101: w_code = OP_WIDTH'(4'd1);
         3'b110: w_code = OP_WIDTH'(4'd3);
         default: begin
            case (ALUFunction)
               6'b100100: w_code = OP_WIDTH'(4'd0);
               6'b100101: w_code = OP_WIDTH'(4'd1);
               6'b100111: w_code = OP_WIDTH'(4'd2);
               6'b100000: w_code = OP_WIDTH'(4'd3);
               6'b100010: w_code = OP_WIDTH'(4'd4);
               6'b000010: w_code = OP_WIDTH'(4'd6);
               6'b000000: w_code = OP_WIDTH'(4'd7);
               6'b101010: w_code = OP_WIDTH'(4'd8);
               6'b001000: begin
                  w_code = OP_WIDTH'(4'd3);
                  w_jr   = 1'b1;
               end
`ifdef ALU_MULDIV_EN
               6'b011000: begin w_code = OP_WIDTH'(4'd10); w_muldiv = 1'b1; end
               6'b011001: begin w_code = OP_WIDTH'(4'd11); w_muldiv = 1'b1; end
               6'b011010: begin w_code = OP_WIDTH'(4'd12); w_muldiv = 1'b1; end
               6'b011011: begin w_code = OP_WIDTH'(4'd13); w_muldiv = 1'b1; end
`endif
               default: begin
                  w_code    = OP_WIDTH'(ILLEGAL_CODE);
                  w_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

`ifdef ALU_MULDIV_EN
   typedef enum logic {S_IDLE, S_RUN} state_t;
   localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES + 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_start;
   logic             r_busy;
   logic             r_done;
   logic             r_stall;

   // Counter holds cycles remaining after the current one; done is raised one edge
   // early so it is visible during the cycle in which the counter reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= '0;
         r_valid   <= 1'b0;
         r_jr      <= 1'b0;
         r_illegal <= 1'b0;
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_stall   <= 1'b0;
      end else if (flush) begin
         r_op      <= '0;
         r_valid   <= 1'b0;
         r_jr      <= 1'b0;
         r_illegal <= 1'b0;
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_stall   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         if (r_state == S_RUN) begin
            if (r_count == '0) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_stall <= 1'b0;
            end else begin
               r_count <= r_count - 1'b1;
               r_done  <= (r_count == CNT_W'(1));
            end
         end else if (enable && !r_stall) begin
            r_valid   <= valid_in;
            r_op      <= valid_in ? w_code : '0;
            r_jr      <= valid_in && w_jr;
            r_illegal <= valid_in && w_illegal;
            if (valid_in && w_muldiv) begin
               r_state <= S_RUN;
               r_count <= CNT_W'(MULDIV_CYCLES - 1);
               r_start <= 1'b1;
               r_busy  <= 1'b1;
               r_stall <= 1'b1;
               r_done  <= (MULDIV_CYCLES == 1);
            end
         end
      end
   end

   assign muldiv_start = r_start;
   assign muldiv_busy  = r_busy;
   assign muldiv_done  = r_done;
   assign stall        = r_stall;
`else
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_op      <= '0;
         r_valid   <= 1'b0;
         r_jr      <= 1'b0;
         r_illegal <= 1'b0;
      end else if (enable) begin
         r_valid   <= valid_in;
         r_op      <= valid_in ? w_code : '0;
         r_jr      <= valid_in && w_jr;
         r_illegal <= valid_in && w_illegal;
      end
   end

   assign muldiv_start = 1'b0;
   assign muldiv_busy  = 1'b0;
   assign muldiv_done  = 1'b0;
   assign stall        = 1'b0;
`endif

   assign ALUOperation = r_op;
   assign valid_out    = r_valid;
   assign jr_flag      = r_jr;
   assign illegal      = r_illegal;

endmodule
